// File: rtl/nf10_axi_lite_master.sv
// nf10_axi_lite_master: single-outstanding AXI4-Lite master behind a simple
// command/response handshake, with a per-transaction timeout.
module nf10_axi_lite_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES   = 1023
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int CW = (C_TIMEOUT_CYCLES > 0) ? $clog2(C_TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((C_TIMEOUT_CYCLES > 0) ? C_TIMEOUT_CYCLES - 1 : 0);
  localparam logic TO_EN = (C_TIMEOUT_CYCLES > 0);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          active;
  logic          expire;
  logic          aw_hs;
  logic          w_hs;
  logic          aw_done;
  logic          w_done;
  logic          resp_hs;

  assign cmd_ready = (state == S_IDLE) & ~areset;
  assign active    = (state == S_WR_REQ) | (state == S_WR_RESP) |
                     (state == S_RD_REQ) | (state == S_RD_DATA);
  // cnt holds the number of active cycles already elapsed, so the current
  // cycle is the last allowed one when cnt reaches TIMEOUT-1.
  assign expire    = TO_EN & active & (cnt == TO_LAST);
  assign aw_hs     = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs      = M_AXI_WVALID & M_AXI_WREADY;
  assign aw_done   = ~M_AXI_AWVALID | M_AXI_AWREADY;
  assign w_done    = ~M_AXI_WVALID | M_AXI_WREADY;
  assign resp_hs   = ((state == S_WR_RESP) & M_AXI_BREADY & M_AXI_BVALID) |
                     ((state == S_RD_DATA) & M_AXI_RREADY & M_AXI_RVALID);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_ARADDR  <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      rsp_timeout   <= 1'b0;
    end else begin
      if (active && cnt != '1) cnt <= cnt + 1'b1;

      // A B/R handshake in the expiry cycle completes normally.
      if (expire && !resp_hs) begin
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_BREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
        rsp_valid     <= 1'b1;
        rsp_timeout   <= 1'b1;
        rsp_resp      <= 2'b10;
        rsp_rdata     <= '0;
        state         <= S_RESP;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_valid) begin
              M_AXI_AWADDR <= cmd_addr;
              M_AXI_ARADDR <= cmd_addr;
              M_AXI_WDATA  <= cmd_wdata;
              M_AXI_WSTRB  <= cmd_wstrb;
              cnt          <= '0;
              if (cmd_write) begin
                M_AXI_AWVALID <= 1'b1;
                M_AXI_WVALID  <= 1'b1;
                state         <= S_WR_REQ;
              end else begin
                M_AXI_ARVALID <= 1'b1;
                state         <= S_RD_REQ;
              end
            end
          end
          S_WR_REQ: begin
            if (aw_hs) M_AXI_AWVALID <= 1'b0;
            if (w_hs)  M_AXI_WVALID  <= 1'b0;
            if (aw_done && w_done) begin
              M_AXI_BREADY <= 1'b1;
              state        <= S_WR_RESP;
            end
          end
          S_WR_RESP: begin
            if (resp_hs) begin
              rsp_resp     <= M_AXI_BRESP;
              rsp_rdata    <= '0;
              rsp_timeout  <= 1'b0;
              rsp_valid    <= 1'b1;
              M_AXI_BREADY <= 1'b0;
              state        <= S_RESP;
            end
          end
          S_RD_REQ: begin
            if (M_AXI_ARREADY) begin
              M_AXI_ARVALID <= 1'b0;
              M_AXI_RREADY  <= 1'b1;
              state         <= S_RD_DATA;
            end
          end
          S_RD_DATA: begin
            if (resp_hs) begin
              rsp_resp     <= M_AXI_RRESP;
              rsp_rdata    <= M_AXI_RDATA;
              rsp_timeout  <= 1'b0;
              rsp_valid    <= 1'b1;
              M_AXI_RREADY <= 1'b0;
              state        <= S_RESP;
            end
          end
          S_RESP: begin
            if (rsp_ready) begin
              rsp_valid <= 1'b0;
              state     <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nf10_axi_lite_master.sv
// Bench for nf10_axi_lite_master: scripted AXI-Lite slave with random delays and a
// transaction-level timing model checked against the DUT every cycle.
module tb_nf10_axi_lite_master;

  localparam int TO      = 8;
  localparam int N_DIR   = 10;
  localparam int N_RAND  = 300;
  localparam int MAX_CYC = 30000;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 aclk = ~aclk;

  nf10_axi_lite_master #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .C_TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          da, dw, db, dar, dr;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    int          hold;
    bit          rst;
  } cmd_t;

  cmd_t dir [N_DIR];
  cmd_t cur, pend;

  int cyc, n_checks, n_err;
  int mstate, t0, fin, e_cyc, ha, hw, hboth, hb, har, hr;
  bit done_ok, pending, in_rst;
  int cur_idx, n_acc, n_done, n_gen, next_cmd_cyc, rst_cyc;
  logic [31:0] e_rdata;
  logic [1:0]  e_resp;
  logic        e_to;
  bit e_cmdr, e_awv, e_wv, e_br, e_arv, e_rr, e_rspv;

  int          lat [N_DIR];
  int          acc_cyc [N_DIR];
  int          rsp_hs_cyc [N_DIR];
  int          aw_hs [N_DIR];
  int          w_hs [N_DIR];
  int          b_hs [N_DIR];
  int          r_hs [N_DIR];
  logic [31:0] obs_rdata [N_DIR];
  logic [1:0]  obs_resp [N_DIR];
  logic        obs_to [N_DIR];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic cmd_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] st, input int da, input int dw, input int db,
                              input int dar, input int dr, input logic [1:0] br,
                              input logic [1:0] rr, input logic [31:0] rd, input int hold,
                              input bit rst);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wd; c.wstrb = st;
    c.da = da; c.dw = dw; c.db = db; c.dar = dar; c.dr = dr;
    c.bresp = br; c.rresp = rr; c.rdata = rd; c.hold = hold; c.rst = rst;
    return c;
  endfunction

  function automatic cmd_t rnd();
    cmd_t c;
    c.wr = ($urandom_range(0, 1) == 1);
    c.addr = $urandom; c.wdata = $urandom; c.wstrb = 4'($urandom_range(0, 15));
    c.da = $urandom_range(0, 3); c.dw = $urandom_range(0, 3); c.db = $urandom_range(0, 4);
    c.dar = $urandom_range(0, 3); c.dr = $urandom_range(0, 5);
    if ($urandom_range(0, 9) == 0) begin c.db += 8; c.dr += 8; end
    if ($urandom_range(0, 19) == 0) begin c.da += 8; c.dar += 8; end
    c.bresp = 2'($urandom_range(0, 3)); c.rresp = 2'($urandom_range(0, 3));
    c.rdata = $urandom; c.hold = -1; c.rst = 1'b0;
    return c;
  endfunction

  initial begin
    dir[0] = mk(1, 32'h7760_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0,  0, 0,  2'b00, 2'b00, 32'h0, 0, 0);
    dir[1] = mk(1, 32'h7760_0014, 32'h1234_5678, 4'h3, 3, 0, 0,  0, 0,  2'b01, 2'b00, 32'h0, 0, 0);
    dir[2] = mk(0, 32'h7760_0004, 32'h0,         4'h0, 0, 0, 0,  0, 5,  2'b00, 2'b10, 32'h10, 0, 0);
    dir[3] = mk(0, 32'h7760_0008, 32'h0,         4'h0, 0, 0, 0, 99, 0,  2'b00, 2'b00, 32'h0, 0, 0);
    dir[4] = mk(0, 32'h7760_000C, 32'h0,         4'h0, 0, 0, 0,  0, 10, 2'b00, 2'b01, 32'hCAFE, 4, 0);
    dir[5] = mk(1, 32'h7760_0018, 32'h3,         4'hF, 0, 0, 7,  0, 0,  2'b11, 2'b00, 32'h0, 0, 0);
    dir[6] = mk(0, 32'h7760_001C, 32'h0,         4'h0, 0, 0, 0,  0, 6,  2'b00, 2'b01, 32'hA5A5_5A5A, 0, 0);
    dir[7] = mk(1, 32'h7760_0020, 32'h0000_55AA, 4'hC, 0, 2, 4,  0, 0,  2'b00, 2'b00, 32'h0, 0, 0);
    dir[8] = mk(1, 32'h7760_0024, 32'h0BAD_F00D, 4'hF, 0, 0, 0,  0, 0,  2'b00, 2'b00, 32'h0, 10, 0);
    dir[9] = mk(1, 32'h7760_0028, 32'h1111_2222, 4'hF, 0, 0, 6,  0, 0,  2'b00, 2'b00, 32'h0, 0, 1);
    for (int i = 0; i < N_DIR; i++) begin
      lat[i] = -1; acc_cyc[i] = -1; rsp_hs_cyc[i] = -1;
      aw_hs[i] = 0; w_hs[i] = 0; b_hs[i] = 0; r_hs[i] = 0;
      obs_rdata[i] = '0; obs_resp[i] = '0; obs_to[i] = 1'b0;
    end
    areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    bresp = '0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    cyc = 0; n_checks = 0; n_err = 0; mstate = 0; pending = 1'b0; n_gen = 0; n_acc = 0;
    n_done = 0; next_cmd_cyc = 0; rst_cyc = -1; cur_idx = 0;
    t0 = 0; fin = 0; e_cyc = 0; ha = 0; hw = 0; hboth = 0; hb = 0; har = 0; hr = 0;
    done_ok = 1'b0; e_rdata = '0; e_resp = '0; e_to = 1'b0;

    while (n_done < N_DIR - 1 + N_RAND && cyc < MAX_CYC) begin
      @(negedge aclk);
      in_rst = (cyc < 3) || (cyc == rst_cyc);
      areset = in_rst;
      if (in_rst) mstate = 0;

      if (!in_rst && !pending && cyc >= next_cmd_cyc && n_gen < N_DIR + N_RAND) begin
        if (n_gen < N_DIR) pend = dir[n_gen];
        else pend = rnd();
        n_gen++;
        pending = 1'b1;
      end
      cmd_valid = pending && !in_rst;
      cmd_write = pend.wr; cmd_addr = pend.addr; cmd_wdata = pend.wdata; cmd_wstrb = pend.wstrb;

      if (mstate == 1) begin
        awready = cur.wr && cyc >= ha;
        wready  = cur.wr && cyc >= hw;
        bvalid  = cur.wr && hboth <= e_cyc && cyc >= hb && !(done_ok && cyc > hb);
        bresp   = cur.bresp;
        arready = !cur.wr && cyc >= har;
        rvalid  = !cur.wr && har <= e_cyc && cyc >= hr && !(done_ok && cyc > hr);
        rdata   = cur.rdata;
        rresp   = cur.rresp;
      end else begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
        bresp = '0; rdata = '0; rresp = '0;
      end
      if (mstate == 1 && cyc > fin)
        rsp_ready = (cur.hold >= 0) ? (cyc > fin + cur.hold) : ($urandom_range(0, 3) != 0);
      else
        rsp_ready = ($urandom_range(0, 1) == 1);

      #1;
      e_cmdr = 0; e_awv = 0; e_wv = 0; e_br = 0; e_arv = 0; e_rr = 0; e_rspv = 0;
      if (in_rst) begin
      end else if (mstate == 0) begin
        e_cmdr = 1;
      end else if (cyc <= fin) begin
        e_awv = cur.wr && cyc <= imin(ha, e_cyc);
        e_wv  = cur.wr && cyc <= imin(hw, e_cyc);
        e_br  = cur.wr && cyc >= hboth + 1 && cyc <= imin(hb, e_cyc);
        e_arv = !cur.wr && cyc <= imin(har, e_cyc);
        e_rr  = !cur.wr && cyc >= har + 1 && cyc <= imin(hr, e_cyc);
      end else begin
        e_rspv = 1;
      end
      chk("cmd_ready", cmd_ready, e_cmdr);
      chk("awvalid", awvalid, e_awv);
      chk("wvalid", wvalid, e_wv);
      chk("bready", bready, e_br);
      chk("arvalid", arvalid, e_arv);
      chk("rready", rready, e_rr);
      chk("rsp_valid", rsp_valid, e_rspv);
      if (in_rst) begin
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_resp", rsp_resp, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
      end else if (e_rspv) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_resp", rsp_resp, e_resp);
        chk("rsp_timeout", rsp_timeout, e_to);
      end
      if (e_awv) chk("awaddr", awaddr, cur.addr);
      if (e_wv) begin
        chk("wdata", wdata, cur.wdata);
        chk("wstrb", wstrb, cur.wstrb);
      end
      if (e_arv) chk("araddr", araddr, cur.addr);

      if (!in_rst && mstate == 1 && cur_idx < N_DIR) begin
        if (rsp_valid && lat[cur_idx] < 0) begin
          lat[cur_idx] = cyc - t0;
          obs_rdata[cur_idx] = rsp_rdata; obs_resp[cur_idx] = rsp_resp; obs_to[cur_idx] = rsp_timeout;
        end
        if (rsp_valid && rsp_ready) rsp_hs_cyc[cur_idx] = cyc;
        if (awvalid && awready) aw_hs[cur_idx]++;
        if (wvalid && wready) w_hs[cur_idx]++;
        if (bvalid && bready) b_hs[cur_idx]++;
        if (rvalid && rready) r_hs[cur_idx]++;
      end
      if (!in_rst && cmd_valid && cmd_ready && n_acc < N_DIR) acc_cyc[n_acc] = cyc;

      if (!in_rst) begin
        if (mstate == 1 && cyc > fin && rsp_ready) begin
          mstate = 0;
          n_done++;
        end else if (mstate == 0 && cmd_valid) begin
          cur = pend; pending = 1'b0; mstate = 1; t0 = cyc; cur_idx = n_acc; n_acc++;
          next_cmd_cyc = cyc + 1 + ((n_gen < N_DIR) ? 0 : $urandom_range(0, 2));
          e_cyc = t0 + TO;
          if (cur.wr) begin
            ha = t0 + 1 + cur.da; hw = t0 + 1 + cur.dw;
            hboth = (ha > hw) ? ha : hw;
            hb = hboth + 1 + cur.db;
            done_ok = (hb <= e_cyc);
            fin = done_ok ? hb : e_cyc;
            har = 0; hr = 0;
          end else begin
            har = t0 + 1 + cur.dar; hr = har + 1 + cur.dr;
            done_ok = (hr <= e_cyc);
            fin = done_ok ? hr : e_cyc;
            ha = 0; hw = 0; hboth = 0; hb = 0;
          end
          if (!done_ok) begin
            e_rdata = '0; e_resp = 2'b10; e_to = 1'b1;
          end else if (cur.wr) begin
            e_rdata = '0; e_resp = cur.bresp; e_to = 1'b0;
          end else begin
            e_rdata = cur.rdata; e_resp = cur.rresp; e_to = 1'b0;
          end
          if (cur.rst) rst_cyc = cyc + 3;
        end
      end
      cyc++;
    end

    chk("completed", n_done, N_DIR - 1 + N_RAND);
    chk("t0_latency", lat[0], 3);
    chk("t0_resp", obs_resp[0], 2'b00);
    chk("t0_rdata", obs_rdata[0], 0);
    chk("t0_timeout", obs_to[0], 0);
    chk("t1_aw_count", aw_hs[1], 1);
    chk("t1_w_count", w_hs[1], 1);
    chk("t1_latency", lat[1], 6);
    chk("t2_rdata", obs_rdata[2], 32'h10);
    chk("t2_resp", obs_resp[2], 2'b10);
    chk("t2_timeout", obs_to[2], 0);
    chk("t3_latency", lat[3], 9);
    chk("t3_timeout", obs_to[3], 1);
    chk("t3_resp", obs_resp[3], 2'b10);
    chk("t3_rdata", obs_rdata[3], 0);
    chk("t4_late_r", r_hs[4], 0);
    chk("t4_timeout", obs_to[4], 1);
    chk("t5_late_b", b_hs[5], 0);
    chk("t5_latency", lat[5], 9);
    chk("t6_latency", lat[6], 9);
    chk("t6_timeout", obs_to[6], 0);
    chk("t8_hold_latency", rsp_hs_cyc[8] - t0_of(8), 13);
    chk("t9_accept_gap", acc_cyc[9] - rsp_hs_cyc[8], 1);
    chk("t9_no_response", lat[9], -1);
    chk("after_reset_accept", acc_cyc[9] >= 0 && n_acc > N_DIR, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  function automatic int t0_of(input int i);
    return acc_cyc[i];
  endfunction

endmodule
